// File: rtl/sram_responder.sv
// Behavioural stand-in for the external 16-bit SRAM: byte-lane writes into a
// local array, pipelined reads driven back onto the shared DQ bus, activity
// counters and sticky protocol error flags.
module sram_responder #(
   parameter int ADDR_W   = 18,
   parameter int DEPTH    = 4096,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [15:0]       SRAM_DQ,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   input  logic              SRAM_UB_N,
   input  logic              SRAM_LB_N,
   input  logic              SRAM_WE_N,
   input  logic              SRAM_CE_N,
   input  logic              SRAM_OE_N,
   output logic [15:0]       wr_count,
   output logic [15:0]       rd_count,
   output logic              oob_err,
   output logic              wr_ovl_err
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [15:0]      mem_q [DEPTH];
   logic             wr;
   logic             rd;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [15:0]      rd_word;

   logic             out_valid;
   logic [15:0]      out_data;
   logic             out_ub;
   logic             out_lb;
   logic             drv;

   logic [15:0]      wr_count_q, wr_count_d;
   logic [15:0]      rd_count_q, rd_count_d;
   logic             oob_q, oob_d;
   logic             ovl_q, ovl_d;

   assign wr       = ~SRAM_CE_N & ~SRAM_WE_N;
   assign rd       = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
   assign in_range = ({1'b0, SRAM_ADDR} < DEPTH_C);
   assign idx      = SRAM_ADDR[IDX_W-1:0];
   assign rd_word  = in_range ? mem_q[idx] : 16'h0000;

   // Array write with per-lane masks; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr && in_range) begin
         if (!SRAM_LB_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
         if (!SRAM_UB_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
      end
   end

   generate
      if (READ_LAT == 0) begin : g_comb
         // Zero latency: the output stage is the live array lookup.
         always_comb begin
            out_valid = rd;
            out_data  = rd_word;
            out_ub    = ~SRAM_UB_N;
            out_lb    = ~SRAM_LB_N;
         end
      end else begin : g_pipe
         logic [READ_LAT-1:0] vld_q, vld_d;
         logic [READ_LAT-1:0] ub_q, ub_d;
         logic [READ_LAT-1:0] lb_q, lb_d;
         logic [15:0]         dat_q [READ_LAT];
         logic [15:0]         dat_d [READ_LAT];

         // Stage 0 captures the fetch; later stages shift one per edge.
         always_comb begin
            vld_d[0] = rd;
            dat_d[0] = rd_word;
            ub_d[0]  = ~SRAM_UB_N;
            lb_d[0]  = ~SRAM_LB_N;
            for (int i = 1; i < READ_LAT; i++) begin
               vld_d[i] = vld_q[i-1];
               dat_d[i] = dat_q[i-1];
               ub_d[i]  = ub_q[i-1];
               lb_d[i]  = lb_q[i-1];
            end
         end

         // Read pipeline register; reset drops any in-flight read.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= '0;
               ub_q  <= '0;
               lb_q  <= '0;
               for (int i = 0; i < READ_LAT; i++) dat_q[i] <= 16'h0000;
            end else begin
               vld_q <= vld_d;
               ub_q  <= ub_d;
               lb_q  <= lb_d;
               for (int i = 0; i < READ_LAT; i++) dat_q[i] <= dat_d[i];
            end
         end

         // Output stage is the last pipeline slot.
         always_comb begin
            out_valid = vld_q[READ_LAT-1];
            out_data  = dat_q[READ_LAT-1];
            out_ub    = ub_q[READ_LAT-1];
            out_lb    = lb_q[READ_LAT-1];
         end
      end
   endgenerate

   // Bus is released the moment the controller leaves read mode or reset hits.
   assign drv           = ~rst & out_valid & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
   assign SRAM_DQ[15:8] = (drv && out_ub) ? out_data[15:8] : 8'hzz;
   assign SRAM_DQ[7:0]  = (drv && out_lb) ? out_data[7:0]  : 8'hzz;

   // Counter and sticky-flag next state; counters wrap silently.
   always_comb begin
      wr_count_d = wr_count_q + {15'd0, wr};
      rd_count_d = rd_count_q + {15'd0, rd};
      oob_d      = oob_q | ((wr | rd) & ~in_range);
      ovl_d      = ovl_q | (wr & out_valid);
   end

   // Counter and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_q <= 16'h0000;
         rd_count_q <= 16'h0000;
         oob_q      <= 1'b0;
         ovl_q      <= 1'b0;
      end else begin
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
         oob_q      <= oob_d;
         ovl_q      <= ovl_d;
      end
   end

   assign wr_count   = wr_count_q;
   assign rd_count   = rd_count_q;
   assign oob_err    = oob_q;
   assign wr_ovl_err = ovl_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (latency 0, 1, 3) share one
// controller stimulus; each DQ net has pull-ups so a released lane reads 8'hFF.
// Written data avoids 8'hFF bytes so a driven lane is never confused with Z.
module tb_sram_responder;
   localparam int ADDR_W = 18;
   localparam int DEPTH  = 4096;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] addr = '0;
   logic              ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1, ub_n = 1'b1, lb_n = 1'b1;
   logic [15:0]       tb_dq = 16'h0000;
   logic              tb_drv = 1'b0;

   wire  [15:0] dq0, dq1, dq3;
   logic [15:0] wc0, rc0, wc1, rc1, wc3, rc3;
   logic        oob0, oob1, oob3, ovl0, ovl1, ovl3;

   always #5 clk = ~clk;

   assign dq0 = tb_drv ? tb_dq : 16'bz;
   assign dq1 = tb_drv ? tb_dq : 16'bz;
   assign dq3 = tb_drv ? tb_dq : 16'bz;

   for (genvar i = 0; i < 16; i++) begin : g_pull
      pullup (dq0[i]);
      pullup (dq1[i]);
      pullup (dq3[i]);
   end

   sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(0)) u_l0 (
      .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .wr_count(wc0), .rd_count(rc0), .oob_err(oob0), .wr_ovl_err(ovl0));
   sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) u_l1 (
      .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .wr_count(wc1), .rd_count(rc1), .oob_err(oob1), .wr_ovl_err(ovl1));
   sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(3)) u_l3 (
      .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .wr_count(wc3), .rd_count(rc3), .oob_err(oob3), .wr_ovl_err(ovl3));

   // Reference model: per-cycle history of bus transactions and a word map.
   typedef struct {
      bit          rd;
      logic [15:0] d;
      bit          ub;
      bit          lb;
   } ev_t;

   ev_t         hist[$];
   logic [15:0] mem_m [int];
   logic [15:0] wc_m = 16'h0000, rc_m = 16'h0000;
   bit          oob_m = 1'b0;
   bit   [2:0]  ovl_m = 3'b000;
   int          total = 0, bad = 0;

   function automatic int lat_of(int k);
      return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
   endfunction

   function automatic bit rd_now();
      return !ce_n && we_n && !oe_n;
   endfunction

   function automatic bit wr_now();
      return !ce_n && !we_n;
   endfunction

   function automatic logic [15:0] word_m(int a);
      if (a >= DEPTH || !mem_m.exists(a)) return 16'h0000;
      return mem_m[a];
   endfunction

   // What the output stage holds right now for latency L.
   function automatic ev_t out_ev(int L);
      ev_t e;
      int  k;
      e = '{rd: 1'b0, d: 16'h0000, ub: 1'b0, lb: 1'b0};
      if (L == 0) begin
         e.rd = rd_now();
         e.d  = word_m(int'(addr));
         e.ub = !ub_n;
         e.lb = !lb_n;
      end else begin
         k = hist.size() - L;
         if (k >= 0) e = hist[k];
      end
      return e;
   endfunction

   function automatic logic [15:0] exp_dq(int L);
      ev_t e;
      bit  drv;
      e   = out_ev(L);
      drv = e.rd && !ce_n && !oe_n && we_n && !rst;
      return {(drv && e.ub) ? e.d[15:8] : 8'hFF, (drv && e.lb) ? e.d[7:0] : 8'hFF};
   endfunction

   function automatic logic [15:0] rand_word();
      return {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      if (we_n) begin
         chk("dq_l0", dq0, exp_dq(0));
         chk("dq_l1", dq1, exp_dq(1));
         chk("dq_l3", dq3, exp_dq(3));
      end
      chk("wr_count_l0", wc0, wc_m);
      chk("wr_count_l1", wc1, wc_m);
      chk("wr_count_l3", wc3, wc_m);
      chk("rd_count_l0", rc0, rc_m);
      chk("rd_count_l1", rc1, rc_m);
      chk("rd_count_l3", rc3, rc_m);
      chk("oob_l0", {15'd0, oob0}, {15'd0, oob_m});
      chk("oob_l1", {15'd0, oob1}, {15'd0, oob_m});
      chk("oob_l3", {15'd0, oob3}, {15'd0, oob_m});
      chk("ovl_l0", {15'd0, ovl0}, {15'd0, ovl_m[0]});
      chk("ovl_l1", {15'd0, ovl1}, {15'd0, ovl_m[1]});
      chk("ovl_l3", {15'd0, ovl3}, {15'd0, ovl_m[2]});
   endtask

   // Apply the effect of one rising edge to the model.
   task automatic model_edge();
      ev_t         e;
      logic [15:0] old;
      int          a;
      a = int'(addr);
      for (int k = 0; k < 3; k++) begin
         e = out_ev(lat_of(k));
         if (wr_now() && e.rd) ovl_m[k] = 1'b1;
      end
      if ((wr_now() || rd_now()) && a >= DEPTH) oob_m = 1'b1;
      if (wr_now()) wc_m = wc_m + 16'd1;
      if (rd_now()) rc_m = rc_m + 16'd1;
      e = '{rd: rd_now(), d: word_m(a), ub: !ub_n, lb: !lb_n};
      hist.push_back(e);
      if (hist.size() > 8) void'(hist.pop_front());
      if (wr_now() && a < DEPTH) begin
         old = word_m(a);
         mem_m[a] = {ub_n ? old[15:8] : tb_dq[15:8], lb_n ? old[7:0] : tb_dq[7:0]};
      end
   endtask

   task automatic model_clear();
      hist.delete();
      wc_m  = 16'h0000;
      rc_m  = 16'h0000;
      oob_m = 1'b0;
      ovl_m = 3'b000;
   endtask

   task automatic cyc(input bit chk_en);
      @(negedge clk);
      if (chk_en) check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_bus(input bit c, input bit w, input bit o, input bit u, input bit l,
                          input int a, input logic [15:0] d);
      ce_n   = c;
      we_n   = w;
      oe_n   = o;
      ub_n   = u;
      lb_n   = l;
      addr   = ADDR_W'(a);
      tb_dq  = d;
      tb_drv = !w;
   endtask

   task automatic set_idle();
      set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 16'h0000);
   endtask

   task automatic set_rd(input int a, input bit u = 1'b0, input bit l = 1'b0);
      set_bus(1'b0, 1'b1, 1'b0, u, l, a, 16'h0000);
   endtask

   task automatic set_wr(input int a, input logic [15:0] d, input bit u = 1'b0, input bit l = 1'b0);
      set_bus(1'b0, 1'b0, 1'b1, u, l, a, d);
   endtask

   task automatic wr(input int a, input logic [15:0] d, input bit u = 1'b0, input bit l = 1'b0);
      set_wr(a, d, u, l);
      cyc(1'b1);
   endtask

   task automatic rdc(input int a, input bit u = 1'b0, input bit l = 1'b0);
      set_rd(a, u, l);
      cyc(1'b1);
   endtask

   task automatic idle();
      set_idle();
      cyc(1'b1);
   endtask

   // Reset asserted mid-cycle; keep_bus leaves the current read on the bus.
   task automatic do_reset(input bit keep_bus);
      if (!keep_bus) set_idle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_clear();
      check_all();
      set_idle();
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      int r, a;
      bit u, l;

      do_reset(1'b0);
      for (int i = 0; i < 64; i++) wr(i, rand_word());
      do_reset(1'b0);

      // Two writes then two reads at latency 1.
      wr(10, 16'h5678);
      wr(11, 16'h1234);
      idle();
      chk("wr_count_two", wc1, 16'd2);
      rdc(10);
      set_rd(11);
      #1 chk("rd10_l1", dq1, 16'h5678);
      cyc(1'b1);
      set_rd(10);
      #1 chk("rd11_l1", dq1, 16'h1234);
      cyc(1'b1);
      idle();
      chk("rd_count_three", rc1, 16'd3);

      // Latency 3: one full-lane read followed by lane-masked reads.
      idle();
      idle();
      idle();
      rdc(10);
      set_rd(11, 1'b1, 1'b1);
      #1 chk("l3_t1_z", dq3, 16'hFFFF);
      cyc(1'b1);
      set_rd(11, 1'b1, 1'b1);
      #1 chk("l3_t2_z", dq3, 16'hFFFF);
      cyc(1'b1);
      set_rd(11, 1'b1, 1'b1);
      #1 chk("l3_t3_drive", dq3, 16'h5678);
      cyc(1'b1);
      set_rd(11, 1'b1, 1'b1);
      #1 chk("l3_t4_z", dq3, 16'hFFFF);
      cyc(1'b1);

      // Latency 0 follows the address combinationally.
      set_rd(11);
      #1 chk("l0_addr11", dq0, 16'h1234);
      addr = ADDR_W'(10);
      #1 chk("l0_addr10", dq0, 16'h5678);
      cyc(1'b1);

      // Byte-lane masks.
      wr(20, 16'h0000);
      wr(20, 16'hAABB, 1'b1, 1'b0);
      rdc(20);
      set_rd(20, 1'b1, 1'b0);
      #1 chk("mask_full", dq1, 16'h00BB);
      cyc(1'b1);
      set_rd(21);
      #1 chk("mask_lb_only", dq1, 16'hFFBB);
      cyc(1'b1);

      // Out-of-range access.
      wr(DEPTH, 16'h1357);
      chk("oob_set", {15'd0, oob1}, 16'd1);
      rdc(DEPTH);
      set_rd(0);
      #1 chk("oob_rd_zero", dq1, 16'h0000);
      cyc(1'b1);
      set_rd(1);
      #1 chk("oob_no_alias", dq1, word_m(0));
      cyc(1'b1);
      idle();
      idle();
      chk("oob_sticky", {15'd0, oob1}, 16'd1);

      // OE_N raised during the output cycle.
      rdc(30);
      set_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30, 16'h0000);
      #1 chk("oe_release", dq1, 16'hFFFF);
      cyc(1'b1);

      // Write colliding with a pending read.
      rdc(31);
      wr(32, 16'h0102);
      idle();
      chk("ovl_set", {15'd0, ovl1}, 16'd1);
      chk("ovl_l0_clear", {15'd0, ovl0}, 16'd0);

      // Random mix against the model.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom_range(0, 63);
         u = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 3) == 0);
         case (r)
            0, 1, 2, 3: set_rd(a, u, l);
            4, 5:       set_wr(a, rand_word(), u, l);
            6:          set_bus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), u, l, a, rand_word());
            7:          set_bus(1'b0, 1'b1, 1'b1, u, l, a, 16'h0000);
            8:          set_rd(DEPTH + $urandom_range(0, 100), u, l);
            default:    set_wr(DEPTH + $urandom_range(0, 100), rand_word(), u, l);
         endcase
         cyc(1'b1);
      end

      // Reset between capture and output.
      idle();
      rdc(40);
      set_rd(41);
      do_reset(1'b1);
      chk("rst_wc_zero", wc3, 16'd0);
      set_rd(42);
      #1 chk("rst_no_drive", dq1, 16'hFFFF);
      cyc(1'b1);
      set_rd(43);
      #1 chk("rst_array_kept", dq1, word_m(42));
      cyc(1'b1);
      idle();

      // Write counter wrap.
      do_reset(1'b0);
      for (int n = 0; n < 65535; n++) begin
         set_wr(50, rand_word());
         cyc(1'b0);
      end
      set_idle();
      #1 chk("wrap_ffff", wc1, 16'hFFFF);
      wr(51, rand_word());
      idle();
      chk("wrap_zero", wc1, 16'h0000);
      chk("wrap_zero_l3", wc3, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Clocked, synthesizable responder for the 16-bit asynchronous-style SRAM bus driven by the team's SRAM controller.
- Stands in for the external SRAM chip in simulation and in FPGA builds without the physical part: holds a 16-bit-wide memory array, accepts writes, and returns read data on the shared DQ bus after a configurable latency.
- Adds activity counters and sticky error flags so benches can check controller behaviour.

Parameters:
- ADDR_W, 18, width of SRAM_ADDR.
- DEPTH, 4096, number of 16-bit words implemented (addresses 0..DEPTH-1); must be ≤ 2^ADDR_W.
- READ_LAT, 1, read latency in clock edges, legal 0..3; 0 = combinational read.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- SRAM_DQ  inout  16  bidirectional data bus; driven by this block only during reads.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_UB_N  in  1  high-byte lane enable (DQ[15:8]), active-low.
- SRAM_LB_N  in  1  low-byte lane enable (DQ[7:0]), active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- wr_count  out  16  number of accepted write edges; wraps at 16'hFFFF.
- rd_count  out  16  number of read captures; wraps at 16'hFFFF.
- oob_err  out  1  sticky: an access addressed ≥ DEPTH.
- wr_ovl_err  out  1  sticky: WE_N fell while read data was being driven.

Behaviour:
- Reset:
  - pipeline valid bits, wr_count, rd_count, oob_err and wr_ovl_err all 0.
  - SRAM_DQ is Z.
  - Array contents are NOT cleared; reset mid-read drops the in-flight read with no drive afterwards.
- Decode on each posedge:
  - WR = ~CE_N & ~WE_N.
  - RD = ~CE_N & WE_N & ~OE_N.
  - Neither condition means idle.
- Write:
  - On a posedge with WR and ADDR < DEPTH: mem[ADDR][7:0] <= DQ[7:0] if ~LB_N; mem[ADDR][15:8] <= DQ[15:8] if ~UB_N.
  - wr_count increments on every WR edge, including when both lanes are masked or the address is out of range.
  - Consecutive WR edges with changing ADDR each write; the controller's two-cycle low/high-half write relies on this.
- Read, READ_LAT ≥ 1:
  - On a posedge with RD, stage 1 captures {valid=1, data=mem[ADDR] (0 if ADDR ≥ DEPTH), ub=~UB_N, lb=~LB_N}.
  - The stage shifts one per edge and reaches the output stage READ_LAT edges after capture.
  - Edges without RD shift in valid=0.
  - Data is fetched at capture time. A write landing after capture is not reflected in that read.
  - rd_count increments on each capture edge.
- Read, READ_LAT = 0:
  - Output stage is combinational: valid=RD, data=mem[ADDR] (0 if ≥ DEPTH), lane enables from the current UB_N/LB_N.
  - rd_count increments on each posedge where RD holds.
- Drive, combinational: drv = out_valid & ~CE_N & ~OE_N & WE_N.
  - DQ[15:8] = out_data[15:8] when drv & out_ub, else Z.
  - DQ[7:0] = out_data[7:0] when drv & out_lb, else Z.
  - Deasserting OE_N or CE_N, or asserting WE_N low, releases the bus in the same cycle.
- Back-to-back reads: one capture per edge; the output updates every edge. The controller's two consecutive read cycles (addr, addr+1) return the two halves on successive cycles after latency.
- Errors:
  - oob_err sets on any WR or RD edge with ADDR ≥ DEPTH.
  - wr_ovl_err sets on a posedge where WR holds and out_valid is 1 (a write collides with a pending read).
  - Both flags clear only on rst.
- Counter wrap: 16'hFFFF + 1 → 16'h0000, no flag.

Test Plan:
- Reset, then write ADDR=10 DQ=16'h5678 and ADDR=11 DQ=16'h1234, both lanes → wr_count=2. Read 10, 11 with READ_LAT=1 → DQ=16'h5678 one edge after the first capture, 16'h1234 the next edge; rd_count=2.
- Byte masks: write ADDR=20 DQ=16'hAABB with UB_N=1, LB_N=0 over prior 16'h0000 → readback 16'h00BB. Read with UB_N=1 → DQ[15:8]=Z, DQ[7:0]=16'hBB.
- READ_LAT=3 build: single RD edge at cycle t → DQ driven only during cycle t+3, Z at t+1, t+2, t+4. READ_LAT=0 → DQ follows ADDR combinationally while RD holds.
- Out of range: write then read ADDR=DEPTH → array unchanged, read returns 16'h0000, oob_err=1 and stays 1 until rst.
- Raise OE_N during the output cycle → DQ Z in that cycle. Assert rst between capture and output → no drive, counters 0, array data still readable after reset.
- WR edge while out_valid=1 → wr_ovl_err=1 and DQ released. Issue 65536 writes → wr_count returns to 16'h0000.
